// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmit data path.
// Frames {left, right} are queued in a small FIFO and serialised MSB first
// on i2s_sdata using externally generated load/shift strobes.
// A left-slot load with an empty FIFO repeats the previous frame and pulses
// underrun.
// Optional build macro: I2S_TX_UNDERRUN_COUNT_EN enables the saturating
// underrun_count tally; without it underrun_count is tied to zero.
module i2s_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 sample_left,
  input  logic [15:0]                 sample_right,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        i2s_lrclk,
  input  logic                        i2s_data_shift_strobe,
  input  logic                        i2s_data_load_strobe,
  output logic                        i2s_sdata,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 underrun_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Frame storage: left word in [31:16], right word in [15:0].
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   frame_q, frame_d;
  logic [15:0]   shift_q, shift_d;
  logic          underrun_q, underrun_d;

  logic        left_load;
  logic        right_load;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] head;

  // Handshake: a frame transfers on any rising edge where sample_valid and
  // sample_ready are both high; sample_ready depends only on the registered
  // level, never on sample_valid, and valid may be dropped at any time.
  assign sample_ready = (level_q < LW'(FIFO_DEPTH));
  assign push         = sample_valid && sample_ready;

  assign left_load  = i2s_data_load_strobe && !i2s_lrclk;
  assign right_load = i2s_data_load_strobe &&  i2s_lrclk;
  // Emptiness comes from the registered level, so a push landing in the
  // same cycle as a left load is not visible to that load.
  assign fifo_empty = (level_q == '0);
  assign pop        = left_load && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  assign fifo_level = level_q;
  assign i2s_sdata  = shift_q[15];
  assign underrun   = underrun_q;

  // Next-state for FIFO bookkeeping, frame register and shift register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    underrun_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A load always wins over a shift in the same cycle.
    if (left_load) begin
      if (!fifo_empty) begin
        frame_d = head;
        shift_d = head[31:16];
      end else begin
        shift_d    = frame_q[31:16];
        underrun_d = 1'b1;
      end
    end else if (right_load) begin
      shift_d = frame_q[15:0];
    end else if (i2s_data_shift_strobe) begin
      shift_d = {shift_q[14:0], 1'b0};
    end
  end

  // FIFO storage write; frames offered during reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {sample_left, sample_right};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      frame_q    <= '0;
      shift_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef I2S_TX_UNDERRUN_COUNT_EN
  logic [15:0] urc_q, urc_d;

  // Saturating tally, stepped together with each underrun pulse.
  always_comb begin
    urc_d = urc_q;
    if (underrun_d && (urc_q != 16'hFFFF)) urc_d = urc_q + 16'd1;
  end

  // Tally register.
  always_ff @(posedge clk) begin
    if (reset) urc_q <= '0;
    else       urc_q <= urc_d;
  end

  assign underrun_count = urc_q;
`else
  assign underrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with hand-computed expectations.
module tb_i2s_tx;

  logic        clk;
  logic        reset;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_lrclk;
  logic        i2s_data_shift_strobe;
  logic        i2s_data_load_strobe;
  logic        i2s_sdata;
  logic        underrun;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_count;

  int n_checks = 0;
  int n_errors = 0;
  int urc_tally = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_frame;
  logic [15:0] word;
  logic [15:0] got_l;
  logic [15:0] got_r;

  i2s_tx #(.FIFO_DEPTH(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .sample_left           (sample_left),
    .sample_right          (sample_right),
    .sample_valid          (sample_valid),
    .sample_ready          (sample_ready),
    .i2s_lrclk             (i2s_lrclk),
    .i2s_data_shift_strobe (i2s_data_shift_strobe),
    .i2s_data_load_strobe  (i2s_data_load_strobe),
    .i2s_sdata             (i2s_sdata),
    .underrun              (underrun),
    .fifo_level            (fifo_level),
    .underrun_count        (underrun_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic load(input logic lr);
    i2s_lrclk            = lr;
    i2s_data_load_strobe = 1'b1;
    step();
    i2s_data_load_strobe = 1'b0;
  endtask

  task automatic do_shift();
    i2s_data_shift_strobe = 1'b1;
    step();
    i2s_data_shift_strobe = 1'b0;
  endtask

  // Collect the 16 bits currently in the shift register, MSB first.
  task automatic read_word(output logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      w[15-i] = i2s_sdata;
      do_shift();
    end
  endtask

  function automatic logic [31:0] sat_tally(input int t);
`ifdef I2S_TX_UNDERRUN_COUNT_EN
    return (t > 65535) ? 32'hFFFF : 32'(t);
`else
    return 32'(t - t);
`endif
  endfunction

  initial begin
    sample_left = '0; sample_right = '0; sample_valid = 1'b0;
    i2s_lrclk = 1'b0; i2s_data_shift_strobe = 1'b0; i2s_data_load_strobe = 1'b0;
    reset = 1'b1;
    step();
    step();
    check_eq("rst_level", 32'(fifo_level), 0);
    check_eq("rst_sdata", 32'(i2s_sdata), 0);
    check_eq("rst_underrun", 32'(underrun), 0);
    check_eq("rst_count", 32'(underrun_count), 0);
    reset = 1'b0;
    step();
    check_eq("rst_ready", 32'(sample_ready), 1);

    // Single frame, bit-by-bit serialisation of both slots.
    push(16'hA5C3, 16'h0F0F);
    check_eq("t1_level_push", 32'(fifo_level), 1);
    load(1'b0);
    check_eq("t1_no_underrun", 32'(underrun), 0);
    check_eq("t1_level_pop", 32'(fifo_level), 0);
    word = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      check_eq("t1_left_bit", 32'(i2s_sdata), 32'(word[15-i]));
      do_shift();
    end
    check_eq("t1_after16", 32'(i2s_sdata), 0);
    do_shift();
    check_eq("t1_after17", 32'(i2s_sdata), 0);
    load(1'b1);
    word = 16'h0F0F;
    for (int i = 0; i < 16; i++) begin
      check_eq("t1_right_bit", 32'(i2s_sdata), 32'(word[15-i]));
      do_shift();
    end

    // Fill to depth, refuse a fifth frame, drain in order across the wrap.
    for (int k = 1; k <= 4; k++) begin
      exp_frame = {16'(16'h1111 * k), 16'(16'h0101 * k)};
      exp_q.push_back(exp_frame);
      push(exp_frame[31:16], exp_frame[15:0]);
    end
    check_eq("t2_level_full", 32'(fifo_level), 4);
    check_eq("t2_ready_full", 32'(sample_ready), 0);
    push(16'h5555, 16'h5555);
    check_eq("t2_level_refused", 32'(fifo_level), 4);
    for (int k = 0; k < 4; k++) begin
      load(1'b0);
      if (k == 0) begin
        check_eq("t2_level_after_pop", 32'(fifo_level), 3);
        check_eq("t2_ready_after_pop", 32'(sample_ready), 1);
      end
      check_eq("t2_no_underrun", 32'(underrun), 0);
      read_word(got_l);
      load(1'b1);
      read_word(got_r);
      exp_frame = exp_q.pop_front();
      check_eq("t2_left_word", 32'(got_l), 32'(exp_frame[31:16]));
      check_eq("t2_right_word", 32'(got_r), 32'(exp_frame[15:0]));
    end
    check_eq("t2_level_drained", 32'(fifo_level), 0);
    load(1'b0);
    check_eq("t2_underrun_after_drain", 32'(underrun), 1);
    urc_tally++;
    read_word(got_l);
    check_eq("t2_repeat_left", 32'(got_l), 32'h4444);

    // Underrun repeats the previous frame and pulses for one cycle.
    push(16'h1234, 16'h5678);
    load(1'b0);
    check_eq("t3_pop_no_underrun", 32'(underrun), 0);
    load(1'b0);
    check_eq("t3_underrun", 32'(underrun), 1);
    check_eq("t3_level", 32'(fifo_level), 0);
    urc_tally++;
    step();
    check_eq("t3_underrun_pulse", 32'(underrun), 0);
    read_word(got_l);
    check_eq("t3_left_repeat", 32'(got_l), 32'h1234);
    load(1'b1);
    read_word(got_r);
    check_eq("t3_right_repeat", 32'(got_r), 32'h5678);

    // Push into an empty FIFO on the left-load cycle is not seen by that load.
    sample_left = 16'hABCD; sample_right = 16'h0001; sample_valid = 1'b1;
    i2s_lrclk = 1'b0; i2s_data_load_strobe = 1'b1;
    step();
    sample_valid = 1'b0; i2s_data_load_strobe = 1'b0;
    check_eq("t4_underrun", 32'(underrun), 1);
    check_eq("t4_level_kept", 32'(fifo_level), 1);
    urc_tally++;
    read_word(got_l);
    check_eq("t4_repeat", 32'(got_l), 32'h1234);
    load(1'b0);
    check_eq("t4_no_underrun", 32'(underrun), 0);
    check_eq("t4_level_pop", 32'(fifo_level), 0);
    read_word(got_l);
    check_eq("t4_queued_frame", 32'(got_l), 32'hABCD);

    // Load and shift in the same cycle: load wins.
    push(16'h8001, 16'h0000);
    i2s_lrclk = 1'b0; i2s_data_load_strobe = 1'b1; i2s_data_shift_strobe = 1'b1;
    step();
    i2s_data_load_strobe = 1'b0; i2s_data_shift_strobe = 1'b0;
    check_eq("t5_sdata_msb", 32'(i2s_sdata), 1);
    read_word(got_l);
    check_eq("t5_word_unshifted", 32'(got_l), 32'h8001);

    // Simultaneous push and pop keeps the level.
    push(16'h0A0A, 16'h0000);
    push(16'h0B0B, 16'h0000);
    sample_left = 16'h0C0C; sample_right = 16'h0000; sample_valid = 1'b1;
    i2s_lrclk = 1'b0; i2s_data_load_strobe = 1'b1;
    step();
    sample_valid = 1'b0; i2s_data_load_strobe = 1'b0;
    check_eq("t6_level_same", 32'(fifo_level), 2);
    read_word(got_l);
    check_eq("t6_first", 32'(got_l), 32'h0A0A);
    load(1'b0);
    read_word(got_l);
    check_eq("t6_second", 32'(got_l), 32'h0B0B);
    load(1'b0);
    read_word(got_l);
    check_eq("t6_third", 32'(got_l), 32'h0C0C);
    check_eq("t6_level_empty", 32'(fifo_level), 0);

    // Underrun tally.
    check_eq("t7_count", 32'(underrun_count), sat_tally(urc_tally));
`ifdef I2S_TX_UNDERRUN_COUNT_EN
    i2s_lrclk = 1'b0; i2s_data_load_strobe = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    i2s_data_load_strobe = 1'b0;
    urc_tally += 70000;
    check_eq("t7_count_sat", 32'(underrun_count), sat_tally(urc_tally));
`endif

    // Reset mid-slot with frames queued; push and strobes in the reset cycle.
    push(16'h0001, 16'h0000);
    push(16'h0002, 16'h0000);
    push(16'h0003, 16'h0000);
    load(1'b0);
    for (int i = 0; i < 5; i++) do_shift();
    check_eq("t8_level_before", 32'(fifo_level), 2);
    reset = 1'b1;
    sample_left = 16'h7777; sample_valid = 1'b1;
    i2s_data_load_strobe = 1'b1; i2s_data_shift_strobe = 1'b1;
    step();
    check_eq("t8_level_rst", 32'(fifo_level), 0);
    check_eq("t8_sdata_rst", 32'(i2s_sdata), 0);
    check_eq("t8_ready_rst", 32'(sample_ready), 1);
    check_eq("t8_underrun_rst", 32'(underrun), 0);
    check_eq("t8_count_rst", 32'(underrun_count), 0);
    reset = 1'b0; sample_valid = 1'b0;
    i2s_data_load_strobe = 1'b0; i2s_data_shift_strobe = 1'b0;
    step();
    check_eq("t8_level_after", 32'(fifo_level), 0);
    check_eq("t8_ready_after", 32'(sample_ready), 1);
    load(1'b0);
    check_eq("t8_underrun_after", 32'(underrun), 1);
    read_word(got_l);
    check_eq("t8_frame_cleared", 32'(got_l), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
